// File: rtl/bemicro_cv_rst_pkg.sv
// Shared types and default timing constants for the BeMicro CV reset sequencer.
package bemicro_cv_rst_pkg;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MEM_REL_DELAY       = 64;
    localparam int DEF_CAL_TIMEOUT_CYCLES  = 1048576;
    localparam int DEF_CNT_W               = 24;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        MEM_DLY,
        WAIT_CAL,
        RUN
    } state_t;

    typedef struct packed {
        logic pll_rst;
        logic mem_rst;
        logic sys_rst;
        logic ready;
    } rst_outs_t;

endpackage

// File: rtl/bemicro_cv_sync2.sv
// Two-flop synchronizer bank with synchronous clear for asynchronous status inputs.
module bemicro_cv_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bemicro_cv_rst_seq.sv
// PLL / DDR3 / system reset sequencer with lock qualification, calibration watch and retry.
module bemicro_cv_rst_seq
    import bemicro_cv_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MEM_REL_DELAY       = DEF_MEM_REL_DELAY,
    parameter int CAL_TIMEOUT_CYCLES  = DEF_CAL_TIMEOUT_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       cal_success,
    input  logic       cal_fail,
    output logic       pll_rst,
    output logic       mem_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic       cal_err
);

    localparam logic [CNT_W-1:0] LD_PLL  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STB  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LOCK = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_MEM  = CNT_W'(MEM_REL_DELAY - 1);
    localparam logic [CNT_W-1:0] LD_CAL  = CNT_W'(CAL_TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_zero;
    logic             do_retry, set_cal_err;
    logic             lk, cs, cf;
    rst_outs_t        outs_q, outs_nxt;

    bemicro_cv_sync2 #(.W(3)) u_sync (
        .clk (clk),
        .clr (rst),
        .d   ({pll_locked, cal_success, cal_fail}),
        .q   ({lk, cs, cf})
    );

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= LD_PLL;
            outs_q    <= '{pll_rst: 1'b1, mem_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0};
            retry_cnt <= '0;
            cal_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            outs_q <= outs_nxt;
            if (do_retry && retry_cnt != 4'hF)
                retry_cnt <= retry_cnt + 4'd1;
            if (set_cal_err)
                cal_err <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_zero ? cnt : cnt - CNT_W'(1);
        do_retry    = 1'b0;
        set_cal_err = 1'b0;
        unique case (state)
            PLL_RST: begin
                if (cnt_zero) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = LD_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABLE;
                    cnt_nxt   = LD_STB;
                end else if (cnt_zero) begin
                    do_retry = 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = LD_LOCK;
                end else if (cnt_zero) begin
                    state_nxt = MEM_DLY;
                    cnt_nxt   = LD_MEM;
                end
            end
            MEM_DLY: begin
                if (!lk) begin
                    do_retry = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = WAIT_CAL;
                    cnt_nxt   = LD_CAL;
                end
            end
            WAIT_CAL: begin
                // A failure beats a simultaneous success; a late success still beats the timeout.
                if (!lk) begin
                    do_retry = 1'b1;
                end else if (cf) begin
                    do_retry    = 1'b1;
                    set_cal_err = 1'b1;
                end else if (cs) begin
                    state_nxt = RUN;
                end else if (cnt_zero) begin
                    do_retry    = 1'b1;
                    set_cal_err = 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    do_retry = 1'b1;
                end else if (cf) begin
                    do_retry    = 1'b1;
                    set_cal_err = 1'b1;
                end
            end
            default: begin
                do_retry = 1'b1;
            end
        endcase
        if (do_retry) begin
            state_nxt = PLL_RST;
            cnt_nxt   = LD_PLL;
        end
    end

    always_comb begin
        outs_nxt = '{pll_rst: 1'b1, mem_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0};
        case (state_nxt)
            WAIT_LOCK, STABLE, MEM_DLY: outs_nxt.pll_rst = 1'b0;
            WAIT_CAL: begin
                outs_nxt.pll_rst = 1'b0;
                outs_nxt.mem_rst = 1'b0;
            end
            RUN: outs_nxt = '{pll_rst: 1'b0, mem_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1};
            default: ;
        endcase
    end

    assign pll_rst = outs_q.pll_rst;
    assign mem_rst = outs_q.mem_rst;
    assign sys_rst = outs_q.sys_rst;
    assign ready   = outs_q.ready;

endmodule

// File: tb/tb_bemicro_cv_rst_seq.sv
// Scoreboard bench: each stimulus pushes the output pattern and latency it should produce.
module tb_bemicro_cv_rst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       cal_success = 1'b0;
    logic       cal_fail = 1'b0;
    logic       pll_rst, mem_rst, sys_rst, ready, cal_err;
    logic [3:0] retry_cnt;
    logic [8:0] obs;

    typedef struct {
        string      tag;
        int         lat;
        logic [8:0] outs;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    bemicro_cv_rst_seq #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MEM_REL_DELAY       (4),
        .CAL_TIMEOUT_CYCLES  (64),
        .CNT_W               (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .cal_success (cal_success),
        .cal_fail    (cal_fail),
        .pll_rst     (pll_rst),
        .mem_rst     (mem_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .retry_cnt   (retry_cnt),
        .cal_err     (cal_err)
    );

    always #5 clk = ~clk;

    assign obs = {pll_rst, mem_rst, sys_rst, ready, cal_err, retry_cnt};

    function automatic logic [8:0] mk(logic p, logic m, logic s, logic r, logic e, int rc);
        return {p, m, s, r, e, 4'(rc)};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic push(string tag, int lat, logic [8:0] outs);
        exp_t e;
        e.tag  = tag;
        e.lat  = lat;
        e.outs = outs;
        sb_q.push_back(e);
    endtask

    // Pop each expectation and count posedges until the outputs reach it, bounded.
    task automatic drain();
        while (sb_q.size() > 0) begin
            exp_t e;
            int   n;
            e = sb_q.pop_front();
            n = 0;
            for (int i = 1; i <= e.lat + 16; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (obs === e.outs) begin
                    n = i;
                    break;
                end
            end
            check({e.tag, "_lat"}, n, e.lat);
            check({e.tag, "_val"}, obs, e.outs);
        end
    endtask

    task automatic expect_after(string tag, int lat, logic [8:0] outs);
        push(tag, lat, outs);
        drain();
    endtask

    // Retry already in progress: pll_rst drops, then mem_rst drops once lock is qualified.
    task automatic relock(string tag, logic e, int rc);
        expect_after({tag, "_pll_lo"}, 4, mk(0, 1, 1, 0, e, rc));
        expect_after({tag, "_mem_lo"}, 13, mk(0, 0, 1, 0, e, rc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", obs, mk(1, 1, 1, 0, 0, 0));

        // Nominal bring-up: sync (2) + decision (1) + stable (8) + mem delay (4).
        rst = 1'b0;
        expect_after("nom_pll_lo", 4, mk(0, 1, 1, 0, 0, 0));
        repeat (6) @(negedge clk);
        pll_locked = 1'b1;
        expect_after("nom_mem_lo", 15, mk(0, 0, 1, 0, 0, 0));
        repeat (20) @(negedge clk);
        cal_success = 1'b1;
        expect_after("nom_run", 3, mk(0, 0, 0, 1, 0, 0));

        // Lock loss in RUN.
        pll_locked  = 1'b0;
        cal_success = 1'b0;
        expect_after("lockloss", 3, mk(1, 1, 1, 0, 0, 1));
        expect_after("lockloss_pll_lo", 4, mk(0, 1, 1, 0, 0, 1));

        // One-cycle lock glitch in STABLE restarts qualification without a retry.
        pll_locked = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        expect_after("glitch_mem_lo", 15, mk(0, 0, 1, 0, 0, 1));

        // Simultaneous success and failure: failure wins.
        cal_success = 1'b1;
        cal_fail    = 1'b1;
        expect_after("calfail_both", 3, mk(1, 1, 1, 0, 1, 2));
        cal_success = 1'b0;
        cal_fail    = 1'b0;
        relock("calfail", 1, 2);

        // Calibration timeout.
        expect_after("caltimeout", 64, mk(1, 1, 1, 0, 1, 3));
        relock("caltimeout", 1, 3);
        cal_success = 1'b1;
        expect_after("caltimeout_run", 3, mk(0, 0, 0, 1, 1, 3));

        cal_success = 1'b0;
        repeat (10) @(negedge clk);
        check("cs_drop_ignored", obs, mk(0, 0, 0, 1, 1, 3));

        cal_fail = 1'b1;
        expect_after("run_calfail", 3, mk(1, 1, 1, 0, 1, 4));
        cal_fail = 1'b0;
        relock("run_calfail", 1, 4);
        cal_success = 1'b1;
        expect_after("run_calfail_run", 3, mk(0, 0, 0, 1, 1, 4));

        // One-cycle reset in RUN.
        rst = 1'b1;
        expect_after("midrst", 1, mk(1, 1, 1, 0, 0, 0));
        rst = 1'b0;
        relock("midrst", 0, 0);
        expect_after("midrst_run", 1, mk(0, 0, 0, 1, 0, 0));

        // Lock never arrives: 4 high + 32 low per attempt, retry count saturates.
        rst         = 1'b1;
        pll_locked  = 1'b0;
        cal_success = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_after("lto_pll_lo", 4, mk(0, 1, 1, 0, 0, 0));
        for (int r = 1; r <= 16; r++) begin
            int rc;
            rc = (r > 15) ? 15 : r;
            expect_after($sformatf("lto%0d_pll_hi", r), 32, mk(1, 1, 1, 0, 0, rc));
            expect_after($sformatf("lto%0d_pll_lo", r), 4, mk(0, 1, 1, 0, 0, rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
